openhw_ramfifo: RTL and testbench

OPENHW_RAMFIFO -- requirements
Module: openhw_ramfifo

---
 rtl/openhw_ramfifo.sv | 124 ++++++++++++
 tb/tb_openhw_ramfifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/openhw_ramfifo.sv
// ---------------------------------------------------------------------------
// openhw_ramfifo
//   Valid/ready FIFO whose storage lives in an external 1R1W byte-enable RAM.
//   The RAM read port is registered: a read is launched by asserting RamCE1
//   with RamRA1, and RamRd1 then holds that entry until the next launch. The
//   head entry is therefore "fetched" one cycle ahead and parked on RamRd1,
//   which is also OutData.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   Flush                 : synchronous discard of all contents
//   InValid/InReady/InData: producer side
//   OutValid/OutReady/OutData : consumer side (OutData == RamRd1)
//   Count                 : entries held, including the head
//   RamCE1/RamRA1/RamRd1  : RAM read port
//   RamCE2/RamWA2/RamWE2/RamBWE2/RamWD2 : RAM write port
// ---------------------------------------------------------------------------
module openhw_ramfifo #(
   parameter int  DEPTH = 1024,
   parameter int  WIDTH = 68,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1,
   localparam int BW    = (WIDTH - 1) / 8 + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData,
   output logic [CW-1:0]    Count,
   output logic             RamCE1,
   output logic [AW-1:0]    RamRA1,
   input  logic [WIDTH-1:0] RamRd1,
   output logic             RamCE2,
   output logic [AW-1:0]    RamWA2,
   output logic             RamWE2,
   output logic [BW-1:0]    RamBWE2,
   output logic [WIDTH-1:0] RamWD2
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          head_valid_q, head_valid_d;

   logic          in_ready;
   logic          push;
   logic          pop;
   logic          fetch;
   logic [CW-1:0] unfetched;

   always_comb begin
      // Full blocks writes even when a pop is pending this cycle, so the
      // write address can never collide with the entry parked on the head.
      in_ready  = (count_q != CW'(DEPTH));
      // Gating with reset keeps both RAM ports quiet while reset is held.
      push      = InValid & in_ready & ~Flush & ~reset;
      pop       = head_valid_q & OutReady & ~Flush & ~reset;
      unfetched = count_q - {{AW{1'b0}}, head_valid_q};
      // Entries counted in count_q were written at an earlier edge, so any
      // of them is safe to read now; the entry being pushed this cycle is not
      // yet counted and cannot be fetched until the following cycle.
      fetch     = (unfetched != '0) & (~head_valid_q | pop) & ~Flush & ~reset;

      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      head_valid_d = head_valid_q;

      if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (fetch) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Popping without a replacement fetch leaves RamRd1 stale: mark empty.
      if (fetch)    head_valid_d = 1'b1;
      else if (pop) head_valid_d = 1'b0;

      if (Flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         head_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
      end
   end

   assign InReady  = in_ready;
   assign OutValid = head_valid_q;
   assign OutData  = RamRd1;
   assign Count    = count_q;

   // Read port only strobes on a fetch so the head data stays put otherwise.
   assign RamCE1  = fetch;
   assign RamRA1  = rd_ptr_q;

   assign RamCE2  = push;
   assign RamWE2  = push;
   assign RamWA2  = wr_ptr_q;
   assign RamBWE2 = {BW{push}};
   assign RamWD2  = InData;

endmodule

// File: tb/tb_openhw_ramfifo.sv
module tb_openhw_ramfifo;
   localparam int DEPTH = 4;
   localparam int WIDTH = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = (WIDTH - 1) / 8 + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             Flush;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] InData;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] OutData;
   logic [CW-1:0]    Count;
   logic             RamCE1;
   logic [AW-1:0]    RamRA1;
   logic [WIDTH-1:0] RamRd1;
   logic             RamCE2;
   logic [AW-1:0]    RamWA2;
   logic             RamWE2;
   logic [BW-1:0]    RamBWE2;
   logic [WIDTH-1:0] RamWD2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   openhw_ramfifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .Flush(Flush),
      .InValid(InValid), .InReady(InReady), .InData(InData),
      .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
      .Count(Count),
      .RamCE1(RamCE1), .RamRA1(RamRA1), .RamRd1(RamRd1),
      .RamCE2(RamCE2), .RamWA2(RamWA2), .RamWE2(RamWE2),
      .RamBWE2(RamBWE2), .RamWD2(RamWD2)
   );

   // External RAM: registered read, byte-enable write.
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (RamCE2 && RamWE2)
         for (int b = 0; b < WIDTH; b++)
            if (RamBWE2[b/8]) mem[RamWA2][b] <= RamWD2[b];
      if (RamCE1) RamRd1 <= mem[RamRA1];
   end

   // Advance one edge; inputs are then changed 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle(); InData = '0;
      step(); #1;
      tests++; if (OutValid !== 1'b0) begin fails++; $display("FAIL reset_outvalid got %0b want 0", OutValid); end
      tests++; if (InReady !== 1'b1) begin fails++; $display("FAIL reset_inready got %0b want 1", InReady); end
      tests++; if (Count !== 0) begin fails++; $display("FAIL reset_count got %0d want 0", Count); end
      tests++; if ({RamCE1, RamCE2, RamWE2} !== 3'b000) begin fails++; $display("FAIL reset_ram_en got %b want 000", {RamCE1, RamCE2, RamWE2}); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single();
      InValid = 1'b1; InData = 16'h00A5; OutReady = 1'b1; #1;
      tests++; if ({RamCE2, RamWE2, RamBWE2} !== 4'b1111 || RamWA2 !== 0 || RamWD2 !== 16'h00A5) begin fails++; $display("FAIL single_write got ce%0b we%0b bwe%b wa%0d wd%h", RamCE2, RamWE2, RamBWE2, RamWA2, RamWD2); end
      step(); InValid = 1'b0; #1;  // after edge 0
      tests++; if (Count !== 1 || OutValid !== 1'b0) begin fails++; $display("FAIL single_e0 got count %0d ov %0b want 1 0", Count, OutValid); end
      tests++; if (RamCE1 !== 1'b1 || RamRA1 !== 0) begin fails++; $display("FAIL single_fetch got ce1 %0b ra %0d want 1 0", RamCE1, RamRA1); end
      step(); #1;  // after edge 1
      tests++; if (OutValid !== 1'b1 || OutData !== 16'h00A5) begin fails++; $display("FAIL single_head got ov %0b data %h want 1 00a5", OutValid, OutData); end
      step(); #1;  // after edge 2 (pop)
      tests++; if (Count !== 0 || OutValid !== 1'b0) begin fails++; $display("FAIL single_pop got count %0d ov %0b want 0 0", Count, OutValid); end
      idle(); step();
   endtask

   task automatic test_full();
      OutReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         InValid = 1'b1; InData = WIDTH'(16'h10 + i); #1;
         if (i == 4) begin
            tests++; if (InReady !== 1'b0) begin fails++; $display("FAIL full_inready got %0b want 0", InReady); end
            tests++; if (RamCE2 !== 1'b0) begin fails++; $display("FAIL full_nowrite got ce2 %0b want 0", RamCE2); end
         end
         step();
      end
      InValid = 1'b0; #1;
      tests++; if (Count !== 4) begin fails++; $display("FAIL full_count got %0d want 4", Count); end
      OutReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         tests++; if (OutValid !== 1'b1 || OutData !== WIDTH'(16'h10 + k)) begin fails++; $display("FAIL full_drain%0d got ov %0b data %h want 1 %h", k, OutValid, OutData, 16'h10 + k); end
         step();
      end
      #1;
      tests++; if (Count !== 0 || OutValid !== 1'b0) begin fails++; $display("FAIL full_empty got count %0d ov %0b want 0 0", Count, OutValid); end
      idle(); step();
   endtask

   task automatic test_back_to_back();
      // Write pointer starts at 1 here (5th push dropped? no: 4 pushes + 1 earlier).
      logic [AW-1:0] wa0;
      OutReady = 1'b0;
      InValid = 1'b1; InData = 16'h0100; #1; wa0 = RamWA2; step();
      InData = 16'h0101; step();
      for (int c = 0; c < 3 * DEPTH; c++) begin
         InValid = 1'b1; InData = WIDTH'(16'h0102 + c); OutReady = 1'b1; #1;
         tests++; if (OutValid !== 1'b1 || OutData !== WIDTH'(16'h0100 + c) || Count !== 2) begin fails++; $display("FAIL stream%0d got ov %0b data %h count %0d want 1 %h 2", c, OutValid, OutData, Count, 16'h0100 + c); end
         tests++; if (RamWA2 !== AW'(wa0 + AW'(2 + c))) begin fails++; $display("FAIL stream_wa%0d got %0d want %0d", c, RamWA2, AW'(wa0 + AW'(2 + c))); end
         step();
      end
      InValid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         tests++; if (OutValid !== 1'b1 || OutData !== WIDTH'(16'h0100 + 3 * DEPTH + k)) begin fails++; $display("FAIL stream_tail%0d got ov %0b data %h", k, OutValid, OutData); end
         step();
      end
      #1;
      tests++; if (Count !== 0) begin fails++; $display("FAIL stream_empty got count %0d want 0", Count); end
      idle(); step();
   endtask

   task automatic test_bubble();
      InValid = 1'b1; InData = 16'h0055; step();
      InValid = 1'b0; step();
      InValid = 1'b1; InData = 16'h0066; OutReady = 1'b1; #1;
      tests++; if (OutValid !== 1'b1 || OutData !== 16'h0055 || Count !== 1) begin fails++; $display("FAIL bubble_pre got ov %0b data %h count %0d want 1 0055 1", OutValid, OutData, Count); end
      step(); InValid = 1'b0; #1;
      tests++; if (OutValid !== 1'b0 || Count !== 1) begin fails++; $display("FAIL bubble_gap got ov %0b count %0d want 0 1", OutValid, Count); end
      step(); #1;
      tests++; if (OutValid !== 1'b1 || OutData !== 16'h0066) begin fails++; $display("FAIL bubble_post got ov %0b data %h want 1 0066", OutValid, OutData); end
      step(); #1;
      tests++; if (Count !== 0) begin fails++; $display("FAIL bubble_empty got count %0d want 0", Count); end
      idle(); step();
   endtask

   task automatic test_flush();
      OutReady = 1'b0;
      for (int i = 0; i < 3; i++) begin InValid = 1'b1; InData = WIDTH'(16'h70 + i); step(); end
      #1;
      tests++; if (Count !== 3) begin fails++; $display("FAIL flush_pre got count %0d want 3", Count); end
      Flush = 1'b1; InValid = 1'b1; OutReady = 1'b1; #1;
      tests++; if ({RamCE1, RamCE2, RamWE2} !== 3'b000) begin fails++; $display("FAIL flush_ram_en got %b want 000", {RamCE1, RamCE2, RamWE2}); end
      step(); Flush = 1'b0; InValid = 1'b0; #1;
      tests++; if (Count !== 0 || OutValid !== 1'b0 || InReady !== 1'b1) begin fails++; $display("FAIL flush_post got count %0d ov %0b ir %0b want 0 0 1", Count, OutValid, InReady); end
      InValid = 1'b1; InData = 16'h0080; #1;
      tests++; if (RamWA2 !== 0) begin fails++; $display("FAIL flush_wptr got %0d want 0", RamWA2); end
      step(); InValid = 1'b0; step(); #1;
      tests++; if (OutValid !== 1'b1 || OutData !== 16'h0080) begin fails++; $display("FAIL flush_refill got ov %0b data %h want 1 0080", OutValid, OutData); end
      step(); idle(); step();
   endtask

   task automatic test_async_reset();
      OutReady = 1'b0;
      for (int i = 0; i < 3; i++) begin InValid = 1'b1; InData = WIDTH'(16'h90 + i); step(); end
      #2 reset = 1'b1; #1;  // mid-cycle, well before the next edge
      tests++; if (Count !== 0 || OutValid !== 1'b0 || InReady !== 1'b1) begin fails++; $display("FAIL areset_state got count %0d ov %0b ir %0b want 0 0 1", Count, OutValid, InReady); end
      tests++; if ({RamCE1, RamCE2, RamWE2} !== 3'b000) begin fails++; $display("FAIL areset_ram_en got %b want 000", {RamCE1, RamCE2, RamWE2}); end
      step(); reset = 1'b0;
      InValid = 1'b1; InData = 16'h0099; #1;
      tests++; if (RamWA2 !== 0) begin fails++; $display("FAIL areset_wptr got %0d want 0", RamWA2); end
      step(); InValid = 1'b0; step(); #1;
      tests++; if (OutValid !== 1'b1 || OutData !== 16'h0099 || Count !== 1) begin fails++; $display("FAIL areset_refill got ov %0b data %h count %0d want 1 0099 1", OutValid, OutData, Count); end
      idle(); step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_bubble();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
